// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction memory shared by fetch and debug, fetch-first with debug anti-starvation
module imem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  logic [3:0]    starve;
  logic [AW-1:0] addr;
  logic          aligned;
  // grants are gated by rst so they drop immediately when reset asserts
  always_comb begin
    dbg_gnt = !rst && dbg_req && (!if_req || starve >= 4'(STARVE_MAX));
    if_gnt = !rst && if_req && !dbg_gnt;
    addr = dbg_gnt ? dbg_addr : if_addr;
    aligned = addr[1:0] == 2'b00;
    mem_en = (if_gnt || dbg_gnt) && aligned;
    mem_we = mem_en && dbg_gnt && dbg_we;
    mem_addr = mem_en ? addr : '0;
    mem_wdata = (mem_en && dbg_gnt) ? dbg_wdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
      if_rvalid <= 1'b0;
      if_err <= 1'b0;
      if_rdata <= '0;
      dbg_rvalid <= 1'b0;
      dbg_err <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      starve <= (dbg_req && !dbg_gnt) ? ((starve == 4'hf) ? starve : starve + 4'd1) : 4'd0;
      if_rvalid <= if_gnt;
      if_err <= if_gnt && !aligned;
      if (if_gnt) if_rdata <= aligned ? mem_rdata : '0;
      dbg_rvalid <= dbg_gnt;
      dbg_err <= dbg_gnt && !aligned;
      if (dbg_gnt) dbg_rdata <= (aligned && !dbg_we) ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed table, hand sequences and random traffic against a scoreboard model
module tb_imem_arbiter;
  localparam int SM = 4;
  localparam logic [31:0] Z = 32'h0;
  localparam logic [31:0] B = 32'hDEADBEEF;
  logic clk = 1'b0, rst = 1'b1, init = 1'b1;
  logic if_req = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] if_addr = '0, dbg_addr = '0, dbg_wdata = '0;
  logic if_gnt, if_rvalid, if_err, dbg_gnt, dbg_rvalid, dbg_err, mem_en, mem_we;
  logic [31:0] if_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int checks = 0, failures = 0, m_cnt = 0;
  logic e_irv, e_ierr, e_drv, e_derr;
  logic [31:0] e_ird, e_drd;

  imem_arbiter #(.STARVE_MAX(SM), .AW(32)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init) for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    else if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  typedef struct {
    logic ir; logic [31:0] ia; logic dr, dw; logic [31:0] da, dd;
    logic ig, dg, men, mwe; logic [31:0] ma, mwd;
    logic irv, ierr; logic [31:0] ird;
    logic drv, derr; logic [31:0] drd;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    e_irv = 0; e_ierr = 0; e_ird = 0; e_drv = 0; e_derr = 0; e_drd = 0;
  endtask

  // scoreboard: who should win, what the memory port shows, what each requester sees next cycle
  task automatic model_step();
    logic dwin, iwin, al;
    logic [31:0] a;
    dwin = dbg_req && (!if_req || m_cnt >= SM);
    iwin = if_req && !dwin;
    a = dwin ? dbg_addr : if_addr;
    al = (a % 4) == 0;
    chk("m_if_gnt", if_gnt, iwin);
    chk("m_dbg_gnt", dbg_gnt, dwin);
    chk("m_mem_en", mem_en, (iwin || dwin) && al);
    chk("m_mem_we", mem_we, dwin && al && dbg_we);
    chk("m_mem_addr", mem_addr, ((iwin || dwin) && al) ? a : Z);
    chk("m_mem_wdata", mem_wdata, (dwin && al) ? dbg_wdata : Z);
    chk("m_if_rvalid", if_rvalid, e_irv);
    chk("m_if_err", if_err, e_ierr);
    chk("m_if_rdata", if_rdata, e_ird);
    chk("m_dbg_rvalid", dbg_rvalid, e_drv);
    chk("m_dbg_err", dbg_err, e_derr);
    chk("m_dbg_rdata", dbg_rdata, e_drd);
    m_cnt = (dbg_req && !dwin) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
    e_irv = iwin; e_ierr = iwin && !al;
    if (iwin) e_ird = al ? ref_mem[a[7:2]] : Z;
    e_drv = dwin; e_derr = dwin && !al;
    if (dwin) e_drd = (al && !dbg_we) ? ref_mem[a[7:2]] : Z;
    if (dwin && al && dbg_we) ref_mem[a[7:2]] = dbg_wdata;
  endtask

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd);
    set_in(ir, ia, dr, dw, da, dd);
    model_step();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    model_reset();
    tv[0]  = '{1'b1, 32'h0,  1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z};
    tv[1]  = '{1'b1, 32'h4,  1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4,  Z, 1'b1, 1'b0, 32'h1000_0000, 1'b0, 1'b0, Z};
    tv[2]  = '{1'b1, 32'h8,  1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8,  Z, 1'b1, 1'b0, 32'h1000_0001, 1'b0, 1'b0, Z};
    tv[3]  = '{1'b0, Z, 1'b1, 1'b1, 32'h10, B, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, B, 1'b1, 1'b0, 32'h1000_0002, 1'b0, 1'b0, Z};
    tv[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, Z, 1'b0, 1'b0, 32'h1000_0002, 1'b1, 1'b0, Z};
    tv[5]  = '{1'b1, 32'h6,  1'b0, 1'b0, Z, Z, 1'b1, 1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b0, B, 1'b0, 1'b0, Z};
    tv[6]  = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, Z, 1'b0, 1'b0, Z};
    tv[7]  = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z};
    tv[8]  = '{1'b0, Z, 1'b1, 1'b0, 32'h14, Z, 1'b0, 1'b1, 1'b1, 1'b0, 32'h14, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z};
    tv[9]  = '{1'b0, Z, 1'b1, 1'b1, 32'h15, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0, 32'h1000_0005};
    tv[10] = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, 1'b1, 1'b1, Z};
    tv[11] = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z};
    // reset state, with both requests high to show grants are held off
    if_req = 1'b1; dbg_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_if_gnt", if_gnt, 0); chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_if_err", if_err, 0); chk("rst_if_rdata", if_rdata, Z);
    chk("rst_dbg_rvalid", dbg_rvalid, 0); chk("rst_dbg_err", dbg_err, 0); chk("rst_dbg_rdata", dbg_rdata, Z);
    @(negedge clk);
    rst = 1'b0; init = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
    // directed table: fetch stream, debug write then fetch-back, misaligned fetch and debug
    for (int i = 0; i < 12; i++) begin
      set_in(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dd);
      chk("tv_if_gnt", if_gnt, tv[i].ig); chk("tv_dbg_gnt", dbg_gnt, tv[i].dg);
      chk("tv_mem_en", mem_en, tv[i].men); chk("tv_mem_we", mem_we, tv[i].mwe);
      chk("tv_mem_addr", mem_addr, tv[i].ma); chk("tv_mem_wdata", mem_wdata, tv[i].mwd);
      chk("tv_if_rvalid", if_rvalid, tv[i].irv); chk("tv_if_err", if_err, tv[i].ierr);
      chk("tv_if_rdata", if_rdata, tv[i].ird); chk("tv_dbg_rvalid", dbg_rvalid, tv[i].drv);
      chk("tv_dbg_err", dbg_err, tv[i].derr); chk("tv_dbg_rdata", dbg_rdata, tv[i].drd);
      model_step();
    end
    // both held: debug wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h40, Z);
      chk("starve_dbg_gnt", dbg_gnt, (i == 4 || i == 9));
    end
    // debug drops after three denials: the wait starts over
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h20, 1'b1, 1'b0, 32'h44, Z);
      chk("drop_pre_gnt", dbg_gnt, 0);
    end
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 32'h44, Z);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h20, 1'b1, 1'b0, 32'h44, Z);
      chk("drop_post_gnt", dbg_gnt, (i == 4));
    end
    // reset asserted while a fetch response is pending/showing
    cyc(1'b1, 32'h28, 1'b0, 1'b0, Z, Z);
    @(posedge clk); #1;
    chk("ar_rvalid_before", if_rvalid, 1);
    rst = 1'b1; #1;
    chk("ar_if_rvalid", if_rvalid, 0); chk("ar_if_rdata", if_rdata, Z);
    chk("ar_if_gnt", if_gnt, 0); chk("ar_mem_en", mem_en, 0);
    model_reset();
    @(negedge clk); #1;
    chk("ar_hold_rvalid", if_rvalid, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h2c; #1;
    chk("ar_first_gnt", if_gnt, 1);
    model_step();
    // random traffic against the scoreboard
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
          rnd_addr(), $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
